// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: serialise a 2-bit command into a framed byte sequence for uart_tx
// Build option: define CMD_FRAME_CHKSUM_EN to append an 8-bit additive checksum byte.
module cmd_frame_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       cmd_vld,
    input  logic       tx_busy,
    output logic [7:0] tx_dout,
    output logic       tx_dout_vld,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       req_drop
);
    localparam logic [7:0] HEAD0 = 8'h55;
    localparam logic [7:0] HEAD1 = 8'hAA;
    localparam logic [7:0] CMD_BASE = 8'h30;
`ifdef CMD_FRAME_CHKSUM_EN
    localparam logic [1:0] LAST = 2'd3;
`else
    localparam logic [1:0] LAST = 2'd2;
`endif
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_GUARD = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] state;
    logic [1:0] idx;
    logic [1:0] cmd_lat;
    logic       pend_vld;
    logic [1:0] pend_cmd;
    logic [7:0] cmd_byte;
    logic [7:0] cur_byte;

    assign cmd_byte = CMD_BASE + {6'd0, cmd_lat};
`ifdef CMD_FRAME_CHKSUM_EN
    logic [7:0] chk;
    assign chk = HEAD0 + HEAD1 + cmd_byte;
    assign cur_byte = idx == 2'd0 ? HEAD0 : idx == 2'd1 ? HEAD1 : idx == 2'd2 ? cmd_byte : chk;
`else
    assign cur_byte = idx == 2'd0 ? HEAD0 : idx == 2'd1 ? HEAD1 : cmd_byte;
`endif

    // Depth-1 request slot: fills while a frame is busy, drains when IDLE launches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_cmd <= 2'd0;
            req_drop <= 1'b0;
        end else begin
            req_drop <= cmd_vld && state != S_IDLE && pend_vld;
            if (state == S_IDLE) begin
                if (pend_vld) begin
                    pend_vld <= cmd_vld;
                    pend_cmd <= cmd;
                end
            end else if (cmd_vld && !pend_vld) begin
                pend_vld <= 1'b1;
                pend_cmd <= cmd;
            end
        end
    end

    // Frame sequencer: one byte per LOAD/SEND/GUARD/WAIT round, then a DONE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            cmd_lat     <= 2'd0;
            tx_dout     <= 8'h00;
            tx_dout_vld <= 1'b0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pend_vld || cmd_vld) begin
                    state      <= S_LOAD;
                    cmd_lat    <= pend_vld ? pend_cmd : cmd;
                    idx        <= 2'd0;
                    frame_busy <= 1'b1;
                end
                S_LOAD: begin
                    tx_dout     <= cur_byte;
                    tx_dout_vld <= 1'b1;
                    state       <= S_SEND;
                end
                S_SEND: begin
                    tx_dout_vld <= 1'b0;
                    state       <= S_GUARD;
                end
                S_GUARD: state <= S_WAIT;
                S_WAIT: if (!tx_busy) begin
                    if (idx == LAST) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    frame_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_frame_tx.sv
// tb_cmd_frame_tx: timestamp-based reference model plus directed and random stimulus for cmd_frame_tx
module tb_cmd_frame_tx;
`ifdef CMD_FRAME_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'd0;
    logic       cmd_vld = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_dout;
    logic       tx_dout_vld;
    logic       frame_busy;
    logic       frame_done;
    logic       req_drop;

    cmd_frame_tx dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld), .tx_busy(tx_busy),
        .tx_dout(tx_dout), .tx_dout_vld(tx_dout_vld), .frame_busy(frame_busy),
        .frame_done(frame_done), .req_drop(req_drop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // reference model: frames as byte queues, events as cycle timestamps
    int  cyc = 0;
    byte unsigned fq[$];
    bit  active = 0, waiting = 0, pend = 0, idle_prev;
    logic [1:0] pcmd = 2'd0;
    int  strobe_at = -1, check_from = 0, done_at = -1;
    logic [7:0] m_dout = 8'h00;
    logic m_vld = 0, m_busy = 0, m_done = 0, m_drop = 0;

    task automatic start_frame(input logic [1:0] c);
        int cb;
        cb = 'h30 + int'(c);
        fq = {8'h55, 8'hAA, 8'(cb)};
`ifdef CMD_FRAME_CHKSUM_EN
        fq.push_back(8'((8'h55 + 8'hAA + cb) % 256));
`endif
        active = 1;
        waiting = 0;
        strobe_at = cyc + 1;
        done_at = -1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            fq.delete();
            active = 0; waiting = 0; pend = 0; pcmd = 2'd0;
            strobe_at = -1; done_at = -1;
            m_dout = 8'h00; m_vld = 0; m_busy = 0; m_done = 0; m_drop = 0;
        end else begin
            idle_prev = !m_busy;
            if (active && done_at == cyc - 1) active = 0;
            m_drop = cmd_vld && !idle_prev && pend;
            if (idle_prev) begin
                if (pend) begin
                    start_frame(pcmd);
                    pend = cmd_vld;
                    pcmd = cmd;
                end else if (cmd_vld) start_frame(cmd);
            end else if (cmd_vld && !pend) begin
                pend = 1;
                pcmd = cmd;
            end
            if (active && waiting && cyc >= check_from && !tx_busy) begin
                waiting = 0;
                if (fq.size() == 0) done_at = cyc;
                else strobe_at = cyc + 1;
            end
            m_vld = strobe_at == cyc;
            if (m_vld) begin
                m_dout = fq.pop_front();
                waiting = 1;
                check_from = cyc + 3;
            end
            m_done = done_at == cyc;
            m_busy = active;
        end
    end

    // every cycle out of reset: DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (!rst)
            chk("cycle", 64'({tx_dout, tx_dout_vld, frame_busy, frame_done, req_drop}),
                64'({m_dout, m_vld, m_busy, m_done, m_drop}));
    end

    // uart_tx stand-in: busy starts d cycles after the strobe and lasts bl cycles
    bit urand = 0, late = 0;
    int ulen = 10;
    initial begin
        int since, d, bl;
        since = 1000; d = 1; bl = 10;
        forever begin
            @(negedge clk);
            if (tx_dout_vld) begin
                since = 0;
                d = urand ? int'($urandom_range(1, 2)) : (late ? 2 : 1);
                bl = urand ? int'($urandom_range(1, 12)) : ulen;
            end else if (since < 1000) since++;
            tx_busy = since >= d && since < d + bl;
        end
    end

    // observed activity, used only for literal expectations
    int n_strb = 0, n_done = 0, n_drop = 0;
    byte unsigned blog[$];
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (tx_dout_vld) begin
                n_strb++;
                blog.push_back(tx_dout);
            end
            n_done += int'(frame_done);
            n_drop += int'(req_drop);
        end
    end

    function automatic logic [63:0] packed_log();
        logic [63:0] pk;
        pk = 64'd0;
        foreach (blog[i]) pk = {pk[55:0], blog[i]};
        return pk;
    endfunction

    task automatic pulse(input logic [1:0] c);
        cmd = c;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd = 2'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_count", 64'(n_done), 64'(target));
    endtask

    initial begin
        int base_d, base_s, base_r, k, dc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 64'({tx_dout, tx_dout_vld, frame_busy, frame_done, req_drop}), 64'd0);

        // single frame
        blog.delete(); base_d = n_done; base_s = n_strb;
`ifdef CMD_FRAME_CHKSUM_EN
        pulse(2'd2);
`else
        pulse(2'd3);
`endif
        wait_done(base_d + 1, 400);
        repeat (20) @(negedge clk);
`ifdef CMD_FRAME_CHKSUM_EN
        chk("single_bytes", packed_log(), 64'h55AA3231);
`else
        chk("single_bytes", packed_log(), 64'h55AA33);
`endif
        chk("single_strobes", 64'(n_strb - base_s), 64'(NB));
        chk("single_dones", 64'(n_done - base_d), 64'd1);

        // queued request plus dropped request
        blog.delete(); base_d = n_done; base_r = n_drop;
        pulse(2'd1);
        repeat (6) @(negedge clk);
        pulse(2'd0);
        repeat (8) @(negedge clk);
        pulse(2'd3);
        wait_done(base_d + 2, 800);
        repeat (5) @(negedge clk);
`ifdef CMD_FRAME_CHKSUM_EN
        chk("queued_bytes", packed_log(), 64'h55AA313055AA302F);
`else
        chk("queued_bytes", packed_log(), 64'h55AA3155AA30);
`endif
        chk("queued_drops", 64'(n_drop - base_r), 64'd1);

        // request during the DONE cycle
        base_r = n_drop;
        pulse(2'd2);
        k = 0;
        while (!frame_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(frame_done), 64'd1);
        dc = cyc;
        cmd = 2'd0;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        k = 0;
        while (!tx_dout_vld && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("relaunch_gap", 64'(cyc - dc), 64'd3);
        wait_done(n_done + 1, 400);
        chk("done_cycle_drops", 64'(n_drop - base_r), 64'd0);

        // reset while waiting on byte 1
        repeat (5) @(negedge clk);
        base_s = n_strb;
        pulse(2'd1);
        k = 0;
        while (n_strb < base_s + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset", 64'({tx_dout, tx_dout_vld, frame_busy, frame_done, req_drop}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_s = n_strb;
        repeat (40) @(negedge clk);
        chk("no_resend", 64'(n_strb - base_s), 64'd0);

        // uart asserting busy one cycle late
        late = 1;
        blog.delete(); base_d = n_done;
        pulse(2'd1);
        wait_done(base_d + 1, 400);
        repeat (3) @(negedge clk);
`ifdef CMD_FRAME_CHKSUM_EN
        chk("late_bytes", packed_log(), 64'h55AA3130);
`else
        chk("late_bytes", packed_log(), 64'h55AA31);
`endif
        late = 0;

        // random traffic, checked cycle by cycle against the model
        urand = 1;
        for (int i = 0; i < 1500; i++) begin
            cmd = 2'($urandom);
            cmd_vld = $urandom_range(0, 9) == 0;
            @(negedge clk);
        end
        cmd_vld = 1'b0;
        repeat (300) @(negedge clk);
        chk("drained", 64'(frame_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
